// File: rtl/sm4_key_schedule.sv
// SM4 key-expansion engine: FK whitening, UNROLL chained T' rounds per clock
// with CK derived arithmetically, a 32-word round-key store, and a
// valid/ready stream of the round keys in encrypt or decrypt order.
module sm4_key_schedule #(
    parameter int UNROLL     = 1,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_valid,
    output logic                  key_ready,
    input  logic [127:0]          key_in,
    input  logic                  mode,
    output logic                  rk_valid,
    input  logic                  rk_ready,
    output logic [WORD_WIDTH-1:0] rk_data,
    output logic [4:0]            rk_idx,
    output logic                  rk_last,
    output logic                  busy
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : g_bad_unroll
        $error("sm4_key_schedule: UNROLL must be 1, 2, 4 or 8");
    end
    if (WORD_WIDTH != 32) begin : g_bad_width
        $error("sm4_key_schedule: WORD_WIDTH must be 32");
    end

    typedef enum logic [1:0] {IDLE, EXPAND, STREAM} state_e;

    localparam logic [31:0] FK [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};

    localparam logic [7:0] SBOX [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    // CK_i byte j = (4i+j)*7 mod 256; the mod falls out of 8-bit arithmetic.
    function automatic logic [31:0] ck_word(input logic [4:0] i);
        logic [31:0] ck;
        logic [7:0]  b;
        ck = '0;
        for (int j = 0; j < 4; j++) begin
            b  = {1'b0, i, 2'b00} + 8'(j);
            ck = {ck[23:0], 8'(b * 8'd7)};
        end
        return ck;
    endfunction

    // Key-path T': byte-wise S-box followed by L'(B) = B ^ (B<<<13) ^ (B<<<23).
    function automatic logic [31:0] t_prime(input logic [31:0] x);
        logic [31:0] t;
        for (int j = 0; j < 4; j++) t[8*j +: 8] = SBOX[x[8*j +: 8]];
        return t ^ {t[18:0], t[31:19]} ^ {t[8:0], t[31:9]};
    endfunction

    state_e      state_q, state_d;
    logic [31:0] k_q [4];
    logic [31:0] k_d [4];
    logic [5:0]  r_q, r_d;
    logic [4:0]  p_q, p_d;
    logic        mode_q, mode_d;
    logic        rk_valid_q, rk_valid_d;
    logic        rk_last_q, rk_last_d;
    logic [31:0] rk_data_q, rk_data_d;
    logic [4:0]  rk_idx_q, rk_idx_d;
    logic [31:0] store [32];
    logic [31:0] rk_new [UNROLL];
    logic [31:0] win_next [4];
    logic        last_round;

    assign last_round = (r_q == 6'(32 - UNROLL));

    // Chain UNROLL rounds combinationally from the current K window.
    always_comb begin
        // NOTE: blocking assignments are intentional here: each unrolled round
        // must see the window the previous round produced in the same cycle.
        for (int w = 0; w < 4; w++) win_next[w] = k_q[w];
        for (int u = 0; u < UNROLL; u++) begin
            rk_new[u] = win_next[0] ^ t_prime(win_next[1] ^ win_next[2] ^ win_next[3]
                                              ^ ck_word(r_q[4:0] + 5'(u)));
            win_next[0] = win_next[1];
            win_next[1] = win_next[2];
            win_next[2] = win_next[3];
            win_next[3] = rk_new[u];
        end
    end

    // Next-state and registered-output logic of the IDLE/EXPAND/STREAM FSM.
    always_comb begin
        // NOTE: every target takes its held value first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        k_d        = k_q;
        r_d        = r_q;
        p_d        = p_q;
        mode_d     = mode_q;
        rk_valid_d = rk_valid_q;
        rk_last_d  = rk_last_q;
        rk_data_d  = rk_data_q;
        rk_idx_d   = rk_idx_q;
        case (state_q)
            IDLE: begin
                if (key_valid) begin
                    for (int w = 0; w < 4; w++) k_d[w] = key_in[127 - 32*w -: 32] ^ FK[w];
                    mode_d  = mode;
                    r_d     = '0;
                    p_d     = '0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                for (int w = 0; w < 4; w++) k_d[w] = win_next[w];
                r_d = r_q + 6'(UNROLL);
                if (last_round) begin
                    // rk31 is only being written this cycle, so decrypt order
                    // takes it straight from the round chain.
                    state_d    = STREAM;
                    p_d        = '0;
                    rk_valid_d = 1'b1;
                    rk_last_d  = 1'b0;
                    rk_idx_d   = mode_q ? 5'd31 : 5'd0;
                    rk_data_d  = mode_q ? rk_new[UNROLL-1] : store[0];
                end
            end
            STREAM: begin
                if (rk_valid_q && rk_ready) begin
                    if (rk_last_q) begin
                        state_d    = IDLE;
                        rk_valid_d = 1'b0;
                        rk_last_d  = 1'b0;
                    end else begin
                        p_d       = p_q + 5'd1;
                        rk_idx_d  = mode_q ? ~p_d : p_d;
                        rk_data_d = store[rk_idx_d];
                        rk_last_d = (p_d == 5'd31);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            r_q        <= '0;
            p_q        <= '0;
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
            rk_data_q  <= '0;
            rk_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            p_q        <= p_d;
            rk_valid_q <= rk_valid_d;
            rk_last_q  <= rk_last_d;
            rk_data_q  <= rk_data_d;
            rk_idx_q   <= rk_idx_d;
        end
    end

    // Key window and latched mode; always reloaded before use.
    always_ff @(posedge clk) begin
        k_q    <= k_d;
        mode_q <= mode_d;
    end

    // Write the UNROLL freshly computed round keys into the store.
    always_ff @(posedge clk) begin
        // NOTE: the store has no reset; every expansion rewrites all 32 words
        // before any of them can be streamed out.
        if (state_q == EXPAND) begin
            for (int u = 0; u < UNROLL; u++) store[r_q[4:0] + 5'(u)] <= rk_new[u];
        end
    end

    assign key_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rk_valid  = rk_valid_q;
    assign rk_last   = rk_last_q;
    assign rk_data   = rk_data_q;
    assign rk_idx    = rk_idx_q;

endmodule

// File: tb/tb_sm4_key_schedule.sv
// Bench for sm4_key_schedule: one instance per UNROLL in {1,2,4,8}, golden
// vectors from a table, reset corner sequences, and random keys checked
// against a plain array-based model of the SM4 key expansion.
module tb_sm4_key_schedule;

    localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [31:0] FK_TB [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};

    localparam logic [7:0] SBOX_TB [256] = '{
        8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
        8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
        8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
        8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
        8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
        8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
        8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
        8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
        8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
        8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
        8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
        8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
        8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
        8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
    };

    typedef struct {
        logic [127:0] key;
        logic         md;
        int           sel;
        int           duty;
        bit           poke;
        int           exp_lat;
        logic [4:0]   exp_first_idx;
        logic [4:0]   exp_last_idx;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in_s;
    logic         mode_s;
    logic         key_valid_a [4];
    logic         key_ready_a [4];
    logic         rk_valid_a  [4];
    logic         rk_ready_a  [4];
    logic [31:0]  rk_data_a   [4];
    logic [4:0]   rk_idx_a    [4];
    logic         rk_last_a   [4];
    logic         busy_a      [4];

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_rk     [32];
    logic [31:0] got_data   [32];
    logic [4:0]  got_idx    [32];
    logic        got_last   [32];
    logic [31:0] got_by_idx [32];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sm4_key_schedule #(.UNROLL(1 << g), .WORD_WIDTH(32)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .key_valid (key_valid_a[g]),
            .key_ready (key_ready_a[g]),
            .key_in    (key_in_s),
            .mode      (mode_s),
            .rk_valid  (rk_valid_a[g]),
            .rk_ready  (rk_ready_a[g]),
            .rk_data   (rk_data_a[g]),
            .rk_idx    (rk_idx_a[g]),
            .rk_last   (rk_last_a[g]),
            .busy      (busy_a[g])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] x);
        return {SBOX_TB[x[31:24]], SBOX_TB[x[23:16]], SBOX_TB[x[15:8]], SBOX_TB[x[7:0]]};
    endfunction

    // Reference expansion over the full K[0..35] sequence.
    task automatic model(input logic [127:0] key);
        logic [31:0] k [36];
        logic [31:0] ck;
        logic [31:0] t;
        for (int i = 0; i < 4; i++) k[i] = key[127 - 32*i -: 32] ^ FK_TB[i];
        for (int i = 0; i < 32; i++) begin
            ck = 32'h0;
            for (int j = 0; j < 4; j++) ck = (ck << 8) | 32'(((4*i + j) * 7) % 256);
            t = tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
            k[i+4] = k[i] ^ t ^ rotl(t, 13) ^ rotl(t, 23);
            exp_rk[i] = k[i+4];
        end
    endtask

    // Randomly re-present a key while busy; the engine must ignore it.
    task automatic busy_noise(input int sel, input bit poke);
        key_in_s = {$urandom(), $urandom(), $urandom(), $urandom()};
        mode_s   = 1'($urandom_range(0, 1));
        if (poke) begin
            key_valid_a[sel] = 1'($urandom_range(0, 1));
            check("key_ready_while_busy", 32'(key_ready_a[sel]), 32'd0);
        end
    endtask

    // Load one key at the current negedge, collect the stream, compare it.
    // abort_at >= 0 pulses rst once that many keys have been handed over.
    task automatic run_stream(input int sel, input logic [127:0] key, input logic md,
                              input int duty, input bit poke, input int abort_at,
                              output int lat);
        int          n;
        int          cyc;
        int          last_hs;
        bit          stalled;
        bit          rdy;
        logic [31:0] pd;
        logic [4:0]  pi;
        logic        pl;
        int          eidx;
        model(key);
        for (int q = 0; q < 32; q++) got_by_idx[q] = 32'h0;
        check("key_ready_idle", 32'(key_ready_a[sel]), 32'd1);
        key_in_s = key;
        mode_s   = md;
        key_valid_a[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        key_valid_a[sel] = 1'b0;
        check("busy_after_accept", 32'(busy_a[sel]), 32'd1);
        lat = 1;
        while (!rk_valid_a[sel] && lat < 100) begin
            rk_ready_a[sel] = 1'($urandom_range(0, 1));
            busy_noise(sel, poke);
            @(negedge clk);
            lat++;
        end
        if (!rk_valid_a[sel]) begin
            check("rk_valid_timeout", 32'(rk_valid_a[sel]), 32'd1);
            key_valid_a[sel] = 1'b0;
            rk_ready_a[sel]  = 1'b0;
            return;
        end
        n = 0; cyc = 0; last_hs = 0; stalled = 1'b0;
        pd = '0; pi = '0; pl = 1'b0;
        while (n < 32 && cyc < 2000) begin
            check("rk_valid_held", 32'(rk_valid_a[sel]), 32'd1);
            if (stalled) begin
                check("stall_data", rk_data_a[sel], pd);
                check("stall_idx", 32'(rk_idx_a[sel]), 32'(pi));
                check("stall_last", 32'(rk_last_a[sel]), 32'(pl));
            end
            if (n == abort_at) begin
                rst = 1'b1;
                rk_ready_a[sel]  = 1'b0;
                key_valid_a[sel] = 1'b0;
                @(negedge clk);
                check("rst_stream_rk_valid", 32'(rk_valid_a[sel]), 32'd0);
                check("rst_stream_rk_last", 32'(rk_last_a[sel]), 32'd0);
                check("rst_stream_busy", 32'(busy_a[sel]), 32'd0);
                check("rst_stream_key_ready", 32'(key_ready_a[sel]), 32'd1);
                check("rst_stream_rk_data", rk_data_a[sel], 32'h0);
                check("rst_stream_rk_idx", 32'(rk_idx_a[sel]), 32'd0);
                rst = 1'b0;
                return;
            end
            rdy = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
            rk_ready_a[sel] = rdy;
            busy_noise(sel, poke);
            if (rk_valid_a[sel] && rdy) begin
                got_data[n] = rk_data_a[sel];
                got_idx[n]  = rk_idx_a[sel];
                got_last[n] = rk_last_a[sel];
                n++;
                last_hs = cyc;
                stalled = 1'b0;
            end else begin
                stalled = rk_valid_a[sel];
                pd = rk_data_a[sel];
                pi = rk_idx_a[sel];
                pl = rk_last_a[sel];
            end
            @(negedge clk);
            cyc++;
        end
        rk_ready_a[sel]  = 1'b0;
        key_valid_a[sel] = 1'b0;
        check("stream_count", 32'(n), 32'd32);
        check("key_ready_after_last", 32'(key_ready_a[sel]), 32'd1);
        check("rk_valid_after_last", 32'(rk_valid_a[sel]), 32'd0);
        check("busy_after_last", 32'(busy_a[sel]), 32'd0);
        if (duty >= 100) check("last_handshake_cycle", 32'(lat + last_hs), 32'(32 / (1 << sel) + 32));
        for (int q = 0; q < n; q++) begin
            eidx = md ? 31 - q : q;
            check("stream_idx", 32'(got_idx[q]), 32'(eidx));
            check("stream_data", got_data[q], exp_rk[eidx]);
            check("stream_last", 32'(got_last[q]), 32'(q == 31));
            got_by_idx[got_idx[q]] = got_data[q];
        end
    endtask

    initial begin
        vec_t        vecs [6];
        int          lat;
        logic [127:0] rkey;

        vecs[0] = '{STD_KEY, 1'b0, 0, 100, 1'b0, 33, 5'd0,  5'd31};
        vecs[1] = '{STD_KEY, 1'b0, 0, 100, 1'b1, 33, 5'd0,  5'd31};
        vecs[2] = '{STD_KEY, 1'b1, 2, 100, 1'b0, 9,  5'd31, 5'd0};
        vecs[3] = '{STD_KEY, 1'b0, 0, 30,  1'b0, 33, 5'd0,  5'd31};
        vecs[4] = '{STD_KEY, 1'b1, 3, 30,  1'b1, 5,  5'd31, 5'd0};
        vecs[5] = '{STD_KEY, 1'b0, 1, 100, 1'b1, 17, 5'd0,  5'd31};

        rst = 1'b1;
        key_in_s = '0;
        mode_s = 1'b0;
        for (int s = 0; s < 4; s++) begin
            key_valid_a[s] = 1'b0;
            rk_ready_a[s]  = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            check("reset_key_ready", 32'(key_ready_a[s]), 32'd1);
            check("reset_rk_valid", 32'(rk_valid_a[s]), 32'd0);
            check("reset_busy", 32'(busy_a[s]), 32'd0);
            check("reset_rk_last", 32'(rk_last_a[s]), 32'd0);
            check("reset_rk_data", rk_data_a[s], 32'h0);
            check("reset_rk_idx", 32'(rk_idx_a[s]), 32'd0);
        end
        rst = 1'b0;

        // Golden-vector table; consecutive entries load back to back.
        for (int v = 0; v < 6; v++) begin
            run_stream(vecs[v].sel, vecs[v].key, vecs[v].md, vecs[v].duty, vecs[v].poke, -1, lat);
            check("vec_latency", 32'(lat), 32'(vecs[v].exp_lat));
            check("vec_first_idx", 32'(got_idx[0]), 32'(vecs[v].exp_first_idx));
            check("vec_last_idx", 32'(got_idx[31]), 32'(vecs[v].exp_last_idx));
            check("vec_rk0", got_by_idx[0], 32'hF12186F9);
            check("vec_rk1", got_by_idx[1], 32'h41662B61);
            check("vec_rk31", got_by_idx[31], 32'h9124A012);
        end

        // Reset with r = 12 in EXPAND (UNROLL=1), then a clean full stream.
        key_in_s = STD_KEY;
        mode_s = 1'b0;
        key_valid_a[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        key_valid_a[0] = 1'b0;
        repeat (12) @(negedge clk);
        check("busy_mid_expand", 32'(busy_a[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_expand_rk_valid", 32'(rk_valid_a[0]), 32'd0);
        check("rst_expand_busy", 32'(busy_a[0]), 32'd0);
        check("rst_expand_key_ready", 32'(key_ready_a[0]), 32'd1);
        rst = 1'b0;
        run_stream(0, STD_KEY, 1'b0, 100, 1'b0, -1, lat);
        check("post_rst_latency", 32'(lat), 32'd33);
        check("post_rst_rk31", got_by_idx[31], 32'h9124A012);

        // Reset with p = 20 in STREAM, then a fresh key with backpressure.
        rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_stream(0, rkey, 1'b1, 100, 1'b0, 20, lat);
        rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_stream(0, rkey, 1'b1, 30, 1'b1, -1, lat);
        check("post_stream_rst_latency", 32'(lat), 32'd33);

        // Random keys across every UNROLL.
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 100; k++) begin
                rkey = {$urandom(), $urandom(), $urandom(), $urandom()};
                run_stream(s, rkey, 1'($urandom_range(0, 1)),
                           ($urandom_range(0, 3) == 0) ? 30 : 100,
                           1'($urandom_range(0, 1)), -1, lat);
                check("sweep_latency", 32'(lat), 32'(32 / (1 << s) + 1));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sm4_key_schedule.md
# sm4_key_schedule

Parametrised SM4 key-expansion engine. It accepts a 128-bit master key, applies the FK whitening, and iterates the key-path T' transform (S-box tau followed by L'(B) = B ^ (B<<<13) ^ (B<<<23)) with on-the-fly CK generation. All 32 round keys land in an internal key store, which is then streamed out in encrypt or decrypt order over a valid/ready interface. It sits between the key-load interface and the round datapath, and replaces the fixed single-round T' path.

## Interface
- UNROLL, 1, rounds computed per clock during expansion; legal values 1, 2, 4, 8; any other value is a synthesis-time error.
- WORD_WIDTH, 32, round-key word width; fixed at 32 by the SM4 algorithm.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  master key and mode are presented.
- key_ready  out  1  engine idle and able to accept a key.
- key_in  in  128  master key MK0..MK3; MK0 = key_in[127:96].
- mode  in  1  output order, sampled with the key: 0 = rk0..rk31 (encrypt), 1 = rk31..rk0 (decrypt).
- rk_valid  out  1  rk_data, rk_idx and rk_last are valid.
- rk_ready  in  1  consumer accepts the current round key.
- rk_data  out  32  round key.
- rk_idx  out  5  algorithmic index i of rk_data, meaning rk_i (not the output position).
- rk_last  out  1  marks the 32nd key of the stream.
- busy  out  1  high in EXPAND and STREAM.

## Operation
- FSM states: IDLE, EXPAND, STREAM.
- IDLE: key_ready = 1. On key_valid & key_ready, the engine:
  - loads K0..K3 = MK ^ FK, where FK = A3B1BAC6, 56AA3350, 677D9197, B27022DC;
  - latches mode;
  - clears round counter r;
  - moves to EXPAND.
- EXPAND: each cycle computes UNROLL chained rounds i = r .. r+UNROLL-1.
  - Round computation: K(i+4) = K(i) ^ T'(K(i+1) ^ K(i+2) ^ K(i+3) ^ CK_i), and rk_i = K(i+4).
  - All UNROLL keys are written to the 32x32 key store in the same cycle. The 4-word K window shifts by UNROLL, and r increments by UNROLL.
  - CK_i byte j (j = 0 is the MSB) = (4i+j)*7 mod 256, generated combinationally from i. No constant ROM is used.
  - Exit: after the cycle that writes rk31 (r reaches 32), go to STREAM. EXPAND lasts exactly 32/UNROLL cycles.
- STREAM:
  - Output pointer p runs 0..31.
  - rk_idx = p for mode 0, and 31-p for mode 1. rk_data = store[rk_idx].
  - p advances on rk_valid & rk_ready.
  - rk_last = 1 when p = 31. The handshake with rk_last returns the FSM to IDLE.
- key_ready = 0 in EXPAND and STREAM. key_valid is ignored there, and no key is queued.
- S-box: 4*UNROLL instances of the team's existing SM4 S-box table, purely combinational inside the round chain.
- Reset (from any state, including mid-EXPAND or mid-STREAM):
  - FSM → IDLE, r = 0, p = 0;
  - rk_valid = 0, rk_last = 0, busy = 0, key_ready = 1 on the cycle after rst is sampled high;
  - rk_data and rk_idx reset to 0;
  - key store contents are not cleared and are don't-care.

## Timing
- Key accepted at rising edge T. busy = 1 from T+1.
- rk_valid first high at T + 32/UNROLL + 1. Examples: UNROLL=1 → T+33; UNROLL=8 → T+5.
- rk_data, rk_idx and rk_last are registered outputs.
- With rk_ready held high, one key is produced per cycle. The last handshake lands at T + 32/UNROLL + 32.
- key_ready rises on the cycle after the rk_last handshake. A new key may be accepted on that same cycle.
- Backpressure: while rk_valid & !rk_ready, rk_data, rk_idx and rk_last must hold stable. rk_valid never drops before its handshake.
- rk_ready asserted outside STREAM has no effect.
- Critical path is UNROLL chained T' stages. No intermediate pipeline registers are inserted inside the round chain.

## Test plan
- Standard vector, mode 0, UNROLL=1:
  - stimulus: key 0123456789ABCDEFFEDCBA9876543210, rk_ready tied to 1;
  - required: rk0 = F12186F9, rk1 = 41662B61, rk31 = 9124A012;
  - required: rk_valid first at T+33, rk_last exactly on rk_idx = 31, 32 keys with no gaps.
- Same key, mode 1, UNROLL=4:
  - first key rk_idx = 31, rk_data = 9124A012;
  - last key rk_idx = 0, rk_data = F12186F9;
  - rk_valid first at T+9.
- Backpressure with random rk_ready (about 30% duty):
  - all 32 values must match the UNROLL=1 golden list;
  - outputs stay stable during stalls;
  - no key is dropped or duplicated.
- key_valid pulses during EXPAND and STREAM:
  - key_ready stays 0 and the stream is unaffected;
  - a back-to-back key presented on the first IDLE cycle is accepted, and its keys match the model.
- rst pulsed mid-EXPAND (r = 12) and again mid-STREAM (p = 20):
  - next cycle: rk_valid = 0, busy = 0, key_ready = 1;
  - a following key yields the correct full 32-key stream.
- Sweep UNROLL ∈ {1, 2, 4, 8}:
  - 100 random keys, compared against the reference model;
  - latency checked against 32/UNROLL + 1.
